lsu_bus_if: RTL
===============

Name: lsu_bus_if

Overview:
- Load/store unit between the core's memory-access controls and an external data bus with a valid/ready handshake.
- Replaces the zero-latency data-memory model with a multicycle bus access.
- Holds the core with a stall output until the access completes.
- Performs byte-lane alignment, write strobes, load sign/zero extension, misalignment detection and a bus timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32 for RV32.
- TIMEOUT, 255, maximum cycles spent in REQ plus RESP before the access is aborted.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- load_code  in  3  000 none, 001 LB, 010 LH, 011 LW, 101 LBU, 110 LHU; other values are treated as none
- store_code  in  2  00 none, 01 SB, 10 SH, 11 SW
- addr  in  ADDR_W  effective address from the execute stage
- data_in  in  32  store data (rs2)
- data_out  out  32  extended load result; valid while done=1
- stall  out  1  freeze PC and register write
- done  out  1  one-cycle completion pulse
- misalign  out  1  one-cycle misaligned-access pulse
- bus_err  out  1  one-cycle timeout pulse
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted
- bus_req_we  out  1  1 = write
- bus_req_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- bus_req_wdata  out  32  lane-shifted store data
- bus_req_strb  out  4  byte enables
- bus_rsp_valid  in  1  response valid
- bus_rsp_rdata  in  32  read word

Behaviour:
- Reset: state IDLE, counter 0. All outputs are 0 (data_out, strb, addr, wdata included).
- FSM states: IDLE, REQ, RESP, DONE, ERR.
- IDLE, no access pending (both codes none): stall=0, no bus activity.
- IDLE, access pending:
  - stall=1 combinationally.
  - If both codes are nonzero, the store wins and the load is ignored.
  - Misaligned means: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned access: go to ERR; no bus transaction is issued.
  - Aligned access: register the request fields, go to REQ.
- Registered request fields:
  - bus_req_addr = {addr[31:2],2'b00}.
  - SB: strb = 0001<<addr[1:0]; wdata = {4{data_in[7:0]}}.
  - SH: strb = 0011<<addr[1:0]; wdata = {2{data_in[15:0]}}.
  - SW: strb = 1111; wdata = data_in.
  - Loads: strb = 0000; we=0.
- REQ:
  - bus_req_valid=1, fields held stable until accepted.
  - On bus_req_ready=1, go to RESP; bus_req_valid drops in the next cycle.
- RESP:
  - Wait for bus_rsp_valid. Stores also wait for a response (write acknowledge).
  - On bus_rsp_valid, select the byte/half at addr[1:0], extend it per the load code, register it into data_out, and go to DONE.
  - A bus_rsp_valid arriving in any state other than RESP is ignored.
- DONE: stall=0, done=1 for exactly one cycle, data_out valid; return to IDLE. The core advances in this cycle, so the same access is never reissued.
- ERR: stall=0, misalign=1 or bus_err=1 for one cycle; data_out=0; return to IDLE.
- Timeout:
  - Counter clears on IDLE→REQ and increments every cycle in REQ or RESP.
  - When it reaches TIMEOUT-1 with no handshake completing in that cycle: bus_req_valid drops, go to ERR with bus_err=1.
  - A handshake in the same cycle as the counter reaching TIMEOUT-1 wins over the timeout.
- Latency: minimum 3 cycles from request to done (IDLE→REQ with ready=1 → RESP with rsp_valid=1 → DONE).
- Reset mid-transaction: at the next clk edge with rst_n=0, return to IDLE and deassert all outputs. Any outstanding response is dropped.
- data_out holds its value outside DONE; the core must sample only on done.

Decomposition:
- Shared package (lsu_pkg):
  - load_code localparams: LD_NONE, LD_B, LD_H, LD_W, LD_BU, LD_HU.
  - store_code localparams: ST_NONE, ST_B, ST_H, ST_W.
  - FSM state encoding.
  - The core's ctrl and mem_data adopt the same constants.
- One sub-module, lsu_align: purely combinational.
  - Store path: strobe and wdata lane generation.
  - Load path: byte/half select and sign/zero extension.
  - Misalignment check.
- lsu_bus_if keeps the FSM, timeout counter and registers.

Test Plan:
- LW to 0x100, ready=1 immediately, rsp one cycle later with rdata 0xDEADBEEF:
  - req_addr=0x100, strb=0000.
  - done at cycle 3, data_out=0xDEADBEEF.
  - stall high in cycles 0–2, low in cycle 3.
- LB to 0x103 with rdata 0x80FF_0000 → data_out=0xFFFFFF80. LBU at the same address → 0x00000080. LH to 0x102 → 0xFFFF80FF.
- SB to 0x201, data_in=0x12345678 → we=1, addr=0x200, strb=0010, wdata=0x78787878. SH to 0x202 → strb=1100, wdata=0x56785678.
- LW to 0x102 → misalign=1 one cycle after the request, bus_req_valid never asserted, data_out=0.
- TIMEOUT=8, bus_req_ready held at 0 → bus_err pulse, bus_req_valid low afterwards, FSM back in IDLE, a following access completes normally.
- rst_n=0 for one cycle while in RESP → bus_req_valid=0, stall=0 and FSM in IDLE. A late bus_rsp_valid produces no done.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access codes and FSM states.
package lsu_pkg;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_B    = 3'b001;
  localparam logic [2:0] LD_H    = 3'b010;
  localparam logic [2:0] LD_W    = 3'b011;
  localparam logic [2:0] LD_BU   = 3'b101;
  localparam logic [2:0] LD_HU   = 3'b110;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_B    = 2'b01;
  localparam logic [1:0] ST_H    = 2'b10;
  localparam logic [1:0] ST_W    = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StResp,
    StDone,
    StErr
  } lsu_state_e;

  // Unlisted load codes behave as "no load".
  function automatic logic ld_is_valid(input logic [2:0] code);
    case (code)
      LD_B, LD_H, LD_W, LD_BU, LD_HU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bus_if_if.sv
// Valid/ready data-bus bundle between the LSU (master) and memory (slave).
interface lsu_bus_if_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  bus_req_valid;
  logic                  bus_req_ready;
  logic                  bus_req_we;
  logic [ADDR_W-1:0]     bus_req_addr;
  logic [DATA_W-1:0]     bus_req_wdata;
  logic [DATA_W/8-1:0]   bus_req_strb;
  logic                  bus_rsp_valid;
  logic [DATA_W-1:0]     bus_rsp_rdata;

  modport master (
    output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_strb,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );

  modport slave (
    input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_strb,
    output bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store strobes/replication, load select/extend,
// and misalignment detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  req_load_i,
  input  logic [1:0]  req_store_i,
  input  logic [1:0]  req_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  strb_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  input  logic [2:0]  rsp_load_i,
  input  logic [1:0]  rsp_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ldata_o
);

  logic [31:0] lane;

  always_comb begin
    strb_o  = 4'b0000;
    wdata_o = 32'h0;
    case (req_store_i)
      ST_B: begin
        strb_o  = 4'b0001 << req_off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      ST_H: begin
        strb_o  = 4'b0011 << req_off_i;
        wdata_o = {2{st_data_i[15:0]}};
      end
      ST_W: begin
        strb_o  = 4'b1111;
        wdata_o = st_data_i;
      end
      default: ;
    endcase
  end

  // A pending store takes priority, so only its size matters when present.
  always_comb begin
    misalign_o = 1'b0;
    if (req_store_i != ST_NONE) begin
      misalign_o = ((req_store_i == ST_H) && req_off_i[0]) ||
                   ((req_store_i == ST_W) && (req_off_i != 2'b00));
    end else begin
      case (req_load_i)
        LD_H, LD_HU: misalign_o = req_off_i[0];
        LD_W:        misalign_o = |req_off_i;
        default:     misalign_o = 1'b0;
      endcase
    end
  end

  assign lane = rdata_i >> {rsp_off_i, 3'b000};

  always_comb begin
    ldata_o = 32'h0;
    case (rsp_load_i)
      LD_B:    ldata_o = {{24{lane[7]}}, lane[7:0]};
      LD_BU:   ldata_o = {24'h0, lane[7:0]};
      LD_H:    ldata_o = {{16{lane[15]}}, lane[15:0]};
      LD_HU:   ldata_o = {16'h0, lane[15:0]};
      LD_W:    ldata_o = rdata_i;
      default: ldata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_bus_if.sv
// Multicycle load/store unit: issues one valid/ready bus access per core request,
// stalls the core until completion, and aborts on misalignment or timeout.
module lsu_bus_if
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        load_code,
  input  logic [1:0]        store_code,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              stall,
  output logic              done,
  output logic              misalign,
  output logic              bus_err,
  lsu_bus_if_if.master      bus
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        strb_q, strb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        ld_code_q, ld_code_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       data_q, data_d;
  logic              mis_q, mis_d;

  logic        pending;
  logic        timed_out;
  logic [3:0]  al_strb;
  logic [31:0] al_wdata;
  logic        al_mis;
  logic [31:0] al_ldata;

  lsu_align u_align (
    .req_load_i  (load_code),
    .req_store_i (store_code),
    .req_off_i   (addr[1:0]),
    .st_data_i   (data_in),
    .strb_o      (al_strb),
    .wdata_o     (al_wdata),
    .misalign_o  (al_mis),
    .rsp_load_i  (ld_code_q),
    .rsp_off_i   (off_q),
    .rdata_i     (bus.bus_rsp_rdata),
    .ldata_o     (al_ldata)
  );

  assign pending   = (store_code != ST_NONE) || ld_is_valid(load_code);
  // >= covers a request handshake on the last count, which enters RESP one past it.
  assign timed_out = (cnt_q >= CntLast);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    strb_d    = strb_q;
    wdata_d   = wdata_q;
    ld_code_d = ld_code_q;
    off_d     = off_q;
    data_d    = data_q;
    mis_d     = mis_q;
    case (state_q)
      StIdle: begin
        if (pending) begin
          if (al_mis) begin
            state_d = StErr;
            mis_d   = 1'b1;
            data_d  = 32'h0;
          end else begin
            state_d   = StReq;
            cnt_d     = '0;
            addr_d    = {addr[ADDR_W-1:2], 2'b00};
            we_d      = (store_code != ST_NONE);
            strb_d    = al_strb;
            wdata_d   = al_wdata;
            ld_code_d = (store_code != ST_NONE) ? LD_NONE : load_code;
            off_d     = addr[1:0];
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.bus_req_ready) begin
          state_d = StResp;
        end else if (timed_out) begin
          state_d = StErr;
          mis_d   = 1'b0;
          data_d  = 32'h0;
        end
      end
      StResp: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.bus_rsp_valid) begin
          state_d = StDone;
          data_d  = al_ldata;
        end else if (timed_out) begin
          state_d = StErr;
          mis_d   = 1'b0;
          data_d  = 32'h0;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      strb_q    <= 4'b0000;
      wdata_q   <= 32'h0;
      ld_code_q <= LD_NONE;
      off_q     <= 2'b00;
      data_q    <= 32'h0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      strb_q    <= strb_d;
      wdata_q   <= wdata_d;
      ld_code_q <= ld_code_d;
      off_q     <= off_d;
      data_q    <= data_d;
      mis_q     <= mis_d;
    end
  end

  assign bus.bus_req_valid = (state_q == StReq);
  assign bus.bus_req_we    = we_q;
  assign bus.bus_req_addr  = addr_q;
  assign bus.bus_req_wdata = wdata_q;
  assign bus.bus_req_strb  = strb_q;

  assign stall    = ((state_q == StIdle) && pending) || (state_q == StReq) ||
                    (state_q == StResp);
  assign done     = (state_q == StDone);
  assign misalign = (state_q == StErr) && mis_q;
  assign bus_err  = (state_q == StErr) && !mis_q;
  assign data_out = data_q;

endmodule
